// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registered valid/ready handshake with a 2-entry skid buffer,
// synchronous flush, bubble gating of RAM/RF write enables and a saturating stall counter.
module id_ex_stage #(
  parameter int DW      = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  input  logic               flush_i,
  input  logic               clr_cnt_i,
  input  logic [1:0]         npc_op_i,
  input  logic               ram_we_i,
  input  logic               rf_we_i,
  input  logic [1:0]         rf_wsel_i,
  input  logic [4:0]         wr_i,
  input  logic [ALUOP_W-1:0] alu_op_i,
  input  logic [DW-1:0]      alua_i,
  input  logic [DW-1:0]      alub_i,
  input  logic [DW-1:0]      ext_i,
  input  logic [DW-1:0]      rD2_i,
  input  logic [DW-1:0]      pc_i,
  output logic [1:0]         npc_op_o,
  output logic               ram_we_o,
  output logic               rf_we_o,
  output logic [1:0]         rf_wsel_o,
  output logic [4:0]         wr_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic [DW-1:0]      alua_o,
  output logic [DW-1:0]      alub_o,
  output logic [DW-1:0]      ext_o,
  output logic [DW-1:0]      rD2_o,
  output logic [DW-1:0]      pc_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  // state    | meaning
  // ST_EMPTY | no instruction held
  // ST_HALF  | M holds the instruction on the outputs, S free
  // ST_FULL  | M on the outputs, S holds the next (younger) one
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]         npc_op;
    logic               ram_we;
    logic               rf_we;
    logic [1:0]         rf_wsel;
    logic [4:0]         wr;
    logic [ALUOP_W-1:0] alu_op;
    logic [DW-1:0]      alua;
    logic [DW-1:0]      alub;
    logic [DW-1:0]      ext;
    logic [DW-1:0]      rd2;
    logic [DW-1:0]      pc;
  } payload_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  payload_t         r_m;
  payload_t         r_s;
  payload_t         w_in;
  logic             w_accept;
  logic             w_pop;
  logic             w_ld_m_in;
  logic             w_ld_m_s;
  logic             w_ld_s_in;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;
  logic             w_cnt_sat;

  assign w_in.npc_op  = npc_op_i;
  assign w_in.ram_we  = ram_we_i;
  assign w_in.rf_we   = rf_we_i;
  assign w_in.rf_wsel = rf_wsel_i;
  assign w_in.wr      = wr_i;
  assign w_in.alu_op  = alu_op_i;
  assign w_in.alua    = alua_i;
  assign w_in.alub    = alub_i;
  assign w_in.ext     = ext_i;
  assign w_in.rd2     = rD2_i;
  assign w_in.pc      = pc_i;

  assign w_accept = in_valid_i & r_in_ready;
  assign w_pop    = r_out_valid & out_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_ld_m_in   = 1'b0;
    w_ld_m_s    = 1'b0;
    w_ld_s_in   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_ld_m_in   = 1'b1;
          w_state_nxt = ST_HALF;
        end
      end
      ST_HALF: begin
        if (w_accept && w_pop) begin
          w_ld_m_in = 1'b1;
        end else if (w_accept) begin
          w_ld_s_in   = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          w_ld_m_s    = 1'b1;
          w_state_nxt = ST_HALF;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // A redirect kills everything, including an instruction arriving this cycle.
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
      w_ld_m_in   = 1'b0;
      w_ld_m_s    = 1'b0;
      w_ld_s_in   = 1'b0;
    end
  end

  // Handshake flags are decoded from the next state so both leave the stage as flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_m <= '0;
      r_s <= '0;
    end else if (flush_i) begin
      r_m <= '0;
      r_s <= '0;
    end else begin
      if (w_ld_m_in) begin
        r_m <= w_in;
      end else if (w_ld_m_s) begin
        r_m <= r_s;
      end
      if (w_ld_s_in) begin
        r_s <= w_in;
      end
    end
  end

  assign w_stall   = r_out_valid & ~out_ready_i;
  assign w_cnt_sat = (r_stall_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !w_cnt_sat) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign npc_op_o    = r_m.npc_op;
  assign ram_we_o    = r_m.ram_we & r_out_valid;
  assign rf_we_o     = r_m.rf_we & r_out_valid;
  assign rf_wsel_o   = r_m.rf_wsel;
  assign wr_o        = r_m.wr;
  assign alu_op_o    = r_m.alu_op;
  assign alua_o      = r_m.alua;
  assign alub_o      = r_m.alub;
  assign ext_o       = r_m.ext;
  assign rD2_o       = r_m.rd2;
  assign pc_o        = r_m.pc;
  assign stall_cnt_o = r_stall_cnt;

endmodule
